// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline.
//   RESET_PC_DEF  : default PC loaded on reset
//   HLT_OPC_DEF   : default opcode (instr[15:12]) that halts fetch
//   NOP_INSTR     : bubble / NOP instruction encoding
//   fetch_state_e : fetch-stage FSM encoding
//   ifid_t        : IF/ID pipeline register contents, IFID_BUBBLE its empty value
package cpu_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [3:0]  HLT_OPC_DEF  = 4'hF;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 16'h0000, pc_plus2: 16'h0000,
                                    valid: 1'b0};

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups with a
// second-level lookahead across groups. The sum wraps modulo 2^16; no carry-out.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (low 16 bits)
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] p;
  // Bit 15 generate only feeds the discarded carry-out, so it is not formed.
  logic [14:0] g;
  logic [15:0] c;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;

  assign p = a ^ b;
  assign g = a[14:0] & b[14:0];

  for (genvar k = 0; k < 3; k++) begin : g_grp_gp
    assign grp_g[k] = g[4*k+3]
                    | (p[4*k+3] & g[4*k+2])
                    | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                    | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign grp_p[k] = &p[4*k+3:4*k];
  end

  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);

  for (genvar k = 0; k < 4; k++) begin : g_bit_c
    assign c[4*k]   = grp_c[k];
    assign c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
    assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
    assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                    | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
  end

  assign sum = p ^ c;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, addresses instruction memory, computes
// PC+2 and registers the fetched word into the IF/ID pipeline register.
// Redirects from ID take priority over stalls; fetching a HLT freezes fetch
// until reset.
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall          : hold PC and IF/ID
//   redirect       : load redirect_pc, squash the instruction in IF
//   redirect_pc    : redirect target (bit 0 forced to 0)
//   imem_addr      : instruction address (= PC)
//   imem_data      : instruction word at imem_addr
//   ifid_instr/pc/pc_plus2/valid : IF/ID register outputs
//   halted         : fetch frozen by HLT
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [3:0]  HLT_OPC  = HLT_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  pc_plus2;
  ifid_t        ifid_q, ifid_d;

  cla_16 u_pc_adder (
    .a   (pc_q),
    .b   (16'h0002),
    .cin (1'b0),
    .sum (pc_plus2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      StRun: begin
        if (redirect) begin
          // Masking keeps the PC halfword-aligned.
          pc_d   = redirect_pc & 16'hFFFE;
          ifid_d = IFID_BUBBLE;
        end else if (!stall) begin
          ifid_d = '{instr: imem_data, pc: pc_q, pc_plus2: pc_plus2, valid: 1'b1};
          if (imem_data[15:12] == HLT_OPC) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      StHalt: begin
        // Redirects are ignored: nothing older than the HLT remains to redirect.
        if (!stall) ifid_d = IFID_BUBBLE;
      end
      default: state_d = StRun;
    endcase
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus2 = ifid_q.pc_plus2;
  assign ifid_valid    = ifid_q.valid;
  assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A behavioural instruction memory answers
// imem_addr combinationally; each scenario pushes the expected post-edge view
// {imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted} when it
// drives a cycle and pops/compares it after the clock edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  logic [15:0] mem [0:32767];
  logic [81:0] sbq [$];
  int          checks;
  int          errors;

  fetch_stage #(
    .RESET_PC (16'h0000),
    .HLT_OPC  (4'hF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  assign imem_data = mem[imem_addr[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_at(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  function automatic logic [81:0] mk(input logic [15:0] addr, input logic [15:0] instr,
                                     input logic [15:0] pc, input logic [15:0] pc2,
                                     input logic valid, input logic hlt);
    return {addr, instr, pc, pc2, valid, hlt};
  endfunction

  function automatic logic [81:0] obs();
    return {imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted};
  endfunction

  task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic test_reset();
    logic [81:0] e;
    rst_n = 1'b0;
    // Inputs active during reset must not disturb the reset state.
    drive(1'b0, 1'b1, 16'h0040);
    repeat (2) @(negedge clk);
    e = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs(), e);
    end
    drive(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
  endtask

  task automatic test_straight();
    logic [81:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0000);
      sbq.push_back(mk(16'(2*i+2), mem_at(16'(2*i)), 16'(2*i), 16'(2*i+2), 1'b1, 1'b0));
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL straight[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_stall();
    logic [81:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 1'b0, 16'h0000);
      if (i < 3)       sbq.push_back(mk(16'h0006, mem_at(16'h4), 16'h4, 16'h6, 1'b1, 1'b0));
      else if (i == 3) sbq.push_back(mk(16'h0008, mem_at(16'h6), 16'h6, 16'h8, 1'b1, 1'b0));
      else             sbq.push_back(mk(16'h000A, mem_at(16'h8), 16'h8, 16'hA, 1'b1, 1'b0));
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL stall[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_redirect_stall();
    logic [81:0] e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive(1'b1, 1'b1, 16'h0041);
        sbq.push_back(mk(16'h0040, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      end else begin
        drive(1'b0, 1'b0, 16'h0000);
        sbq.push_back(mk(16'h0042, mem_at(16'h40), 16'h0040, 16'h0042, 1'b1, 1'b0));
      end
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL redirect_stall[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  // PC is now 0x42, where memory holds a HLT; the redirect must squash it.
  task automatic test_squash_hlt();
    logic [81:0] e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        drive(1'b0, 1'b1, 16'h0020);
        sbq.push_back(mk(16'h0020, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      end else begin
        drive(1'b0, 1'b0, 16'h0000);
        sbq.push_back(mk(16'(16'h0020 + 2*i), mem_at(16'(16'h001E + 2*i)),
                         16'(16'h001E + 2*i), 16'(16'h0020 + 2*i), 1'b1, 1'b0));
      end
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL squash_hlt[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [81:0] e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        drive(1'b0, 1'b1, 16'hFFFE);
        sbq.push_back(mk(16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      end else if (i == 1) begin
        drive(1'b0, 1'b0, 16'h0000);
        sbq.push_back(mk(16'h0000, mem_at(16'hFFFE), 16'hFFFE, 16'h0000, 1'b1, 1'b0));
      end else begin
        drive(1'b0, 1'b0, 16'h0000);
        sbq.push_back(mk(16'h0002, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b0));
      end
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_hlt();
    logic [81:0] e;
    logic [81:0] bub_halt;
    logic [81:0] hlt_view;
    bub_halt = mk(16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    hlt_view = mk(16'h0010, 16'hF000, 16'h0010, 16'h0012, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      unique case (i)
        0: begin
          drive(1'b0, 1'b1, 16'h0010);
          sbq.push_back(mk(16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
        end
        1: begin drive(1'b0, 1'b0, 16'h0000); sbq.push_back(hlt_view); end
        2: begin drive(1'b1, 1'b0, 16'h0000); sbq.push_back(hlt_view); end
        3: begin drive(1'b0, 1'b1, 16'h0030); sbq.push_back(bub_halt); end
        default: begin drive(1'b0, 1'b0, 16'h0000); sbq.push_back(bub_halt); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL hlt[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [81:0] e;
    drive(1'b1, 1'b1, 16'h0030);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    sbq.push_back(mk(16'h0002, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b0));
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL after_reset: got %h expected %h", obs(), e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32768; i++) mem[i] = {4'h2, 12'(i)};
    mem[16'h0000 >> 1] = 16'h1234;
    mem[16'h0002 >> 1] = 16'h5678;
    mem[16'h0010 >> 1] = 16'hF000;
    mem[16'h0042 >> 1] = 16'hF123;
    test_reset();
    test_straight();
    test_stall();
    test_redirect_stall();
    test_squash_hlt();
    test_wrap();
    test_hlt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU. Holds the architectural PC, drives the instruction-memory address, and computes PC+2. Registers the fetched instruction into the IF/ID pipeline register. Accepts branch/jump redirects from the next-PC selection logic in ID, plus stalls from the hazard unit, and freezes fetch permanently once a HLT instruction is fetched.

## Interface
Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- HLT_OPC, 4'hF: opcode (instr[15:12]) that halts fetch.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit; hold PC and IF/ID contents.
- redirect  in  1  branch/jump taken in ID; load redirect_pc and squash the instruction currently in IF.
- redirect_pc  in  16  target PC from next-PC selection.
- imem_addr  out  16  instruction-memory address, equal to PC (combinational from the PC register).
- imem_data  in  16  instruction word at imem_addr, combinational read.
- ifid_instr  out  16  registered instruction.
- ifid_pc  out  16  PC of ifid_instr.
- ifid_pc_plus2  out  16  ifid_pc + 2, consumed by the next-PC logic.
- ifid_valid  out  1  ifid_instr is a real instruction; 0 = bubble.
- halted  out  1  fetch frozen by HLT.

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- RUN, per cycle, in priority order:
  - **redirect=1:** PC <= {redirect_pc[15:1],1'b0}. IF/ID becomes a bubble (valid=0, instr=16'h0000, pc fields 0). State stays RUN. Redirect wins over stall.
  - **stall=1:** PC, IF/ID and state hold.
  - **Otherwise:**
    - IF/ID <= {imem_data, PC, PC+2}, valid=1.
    - If imem_data[15:12]==HLT_OPC, state <= HALT and PC holds.
    - If not HLT, PC <= PC+2.
- HALT:
  - PC holds.
  - halted=1.
  - While stall=1, IF/ID holds.
  - Otherwise IF/ID loads a bubble.
  - redirect is ignored, because no older instruction can still redirect once the HLT has passed IF.
  - Only reset exits HALT.
- A HLT in IF during a redirect cycle is squashed and does not halt.
- PC arithmetic is modulo 2^16: 16'hFFFE + 2 = 16'h0000, with no error flag.
- PC bit 0 is always 0.

## Timing
- Reset values:
  - PC=RESET_PC, so imem_addr=RESET_PC.
  - ifid_instr=16'h0000, ifid_pc=0, ifid_pc_plus2=0, ifid_valid=0.
  - halted=0, state RUN.
- Reset is asynchronous mid-operation: all of the above take effect immediately, regardless of stall or redirect.
- Fetch-to-IF/ID latency is 1 cycle. The first valid IF/ID appears on the first rising edge after rst_n deasserts.
- Redirect is seen in the same cycle it is asserted. The target is fetched the next cycle and valid in IF/ID the cycle after, giving a 1-bubble penalty.
- halted asserts in the cycle after the HLT edge, in the same cycle HLT appears in IF/ID.
- imem_addr has zero latency from the PC register. imem_data must settle within the cycle.

## Structure
- Shared package `cpu_pkg`:
  - RESET_PC default.
  - HLT opcode.
  - bubble/NOP encoding 16'h0000.
  - FSM state encoding (RUN=1'b0, HALT=1'b1).
- Sub-module: reuse the existing `cla_16` adder for PC+2 (b=16'h2, cin=0). No other sub-modules.
- The IF/ID register lives inside this block, not in the top level.

## Test plan
- **Reset and straight-line fetch:** rst_n low then high, imem returns 16'h1234 at 0 and 16'h5678 at 2. Expect imem_addr 0→2→4, ifid_instr 16'h1234 (pc 0, pc_plus2 2, valid 1) then 16'h5678.
- **Stall:** stall high for 3 cycles at PC=6. Expect imem_addr stays 6 and IF/ID frozen. After release, fetch resumes at 6 and then 8.
- **Redirect during stall:** redirect=1, redirect_pc=16'h0041, stall=1. Expect PC=16'h0040 next cycle, ifid_valid=0, then the instruction at 0x40 valid one cycle later.
- **HLT fetch:** imem_data=16'hF000 at PC=0x10. Expect IF/ID holds HLT with valid=1, halted=1, imem_addr stuck at 0x10. Later redirects are ignored and IF/ID shows bubbles thereafter.
- **Squashed HLT:** HLT in IF with redirect=1 to 0x20. Expect no halt, PC=0x20, bubble in IF/ID.
- **Wrap and async reset:**
  - Redirect to 16'hFFFE; expect the next PC to be 16'h0000.
  - Then assert rst_n low mid-cycle; expect PC, IF/ID and halted cleared immediately, without waiting for a clock edge.
